sign_mag_disp: RTL and testbench
================================

Name: sign_mag_disp

Overview:
- Downstream display stage for the sign-magnitude adder: takes an N-bit sign-magnitude result and shows it on a 4-digit, time-multiplexed, common-anode seven-segment display.
- The leftmost digit shows the sign; the other three digits show the decimal magnitude.
- The magnitude is converted to BCD sequentially (shift-add-3) under a small FSM, then latched into display registers.
- The display registers are scanned by a free-running refresh counter.

Parameters:
- N, 8, width of the sign-magnitude input: bit N-1 is the sign, bits N-2:0 are the magnitude. Legal range 2..10, so the magnitude is at most 511 and fits 3 digits.
- REFRESH_BITS, 18, width of the refresh counter. The top 2 bits select the digit. Benches use 4.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous reset, active-low
- start  input  1  request conversion of sm_in; accepted only while ready=1
- sm_in  input  N  sign-magnitude value; sampled on the accepting edge
- ready  output  1  high in IDLE
- done_tick  output  1  one-cycle pulse; the new value is latched into the display on this cycle's closing edge
- an  output  4  digit enables, active-low; an[3] is the leftmost digit
- sseg  output  8  segments, active-low; bit7=dp, bits6:0=g..a

Behaviour:
- Reset (reset_n=0 at a clk edge): FSM=IDLE, ready=1, done_tick=0, refresh counter=0, display BCD=000, sign=0, so an=4'b1110 and sseg=8'hC0. Reset mid-conversion aborts the conversion and leaves no partial update.
- FSM IDLE: start=1 at the edge loads the magnitude register with sm_in[N-2:0], captures the sign (sign forced to 0 if the magnitude is 0), clears the working BCD, sets iteration count=N-1 and goes to CONV.
- FSM CONV: each cycle, add 3 to every working BCD digit that is >=5, then shift {bcd,mag} left by 1. Decrement the count; after N-1 shifts go to DONE.
- FSM DONE: done_tick=1 for exactly this cycle. On the closing edge, the display registers take the working BCD and sign, and the FSM returns to IDLE.
- Latency: start edge at t gives done_tick high during the cycle after edge t+N-1. The display shows the new value from edge t+N. ready is low from edge t to edge t+N.
- start while busy is ignored, with no queuing. The sm_in change after acceptance has no effect.
- Negative zero (e.g. 8'h80) displays as 000 with no minus sign.
- Scan: the refresh counter increments every cycle and wraps freely; it is unaffected by the FSM.
  - sel=cnt[REFRESH_BITS-1 -: 2]; sel=0..3 enables an[sel] only.
  - Digit0=ones, digit1=tens, digit2=hundreds, digit3=sign: 8'hBF (minus) if negative, 8'hFF (blank) if not.
- Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. dp is always off (1).
- The display keeps its last value indefinitely between conversions.

Optional Feature:
- Macro: SIGN_MAG_DISP_LZ_BLANK_EN
- Defined: leading-zero blanking. Hundreds is blanked (FF) if 0; tens is blanked if both hundreds and tens are 0; ones is never blanked. The minus sign stays on digit3.
- Undefined: all three magnitude digits are always shown.

Decomposition:
- Package sign_mag_pkg:
  - FSM state enum (IDLE, CONV, DONE)
  - segment constants: SEG_MINUS=8'hBF, SEG_BLANK=8'hFF
  - digit-to-segment lookup function
  - N range limits
- One sub-module, sm_bcd_conv: the FSM plus the shift-add-3 datapath, exposing start/ready/done_tick/bcd/sign. The top level adds the display registers and the scan mux.

Test Plan (N=8, REFRESH_BITS=4):
- Reset, then hold reset_n=1 → ready=1, an=1110, sseg=C0; an steps 1110,1101,1011,0111 every 4 cycles, then wraps.
- start with sm_in=8'h85 (−5) → done_tick pulses exactly 8 cycles after the start edge; digits "-005" (digit3=BF, digit2=C0, digit1=C0, digit0=92). With LZ_BLANK_EN: "-  5".
- sm_in=8'h7F → "127", digit3=FF; sm_in=8'hFF → "-127".
- sm_in=8'h80 (negative zero) → digit3=FF, digits "000".
- start pulsed again 3 cycles into CONV with 8'h01 → ignored; the first conversion's result is shown and there is one done_tick only.
- reset_n=0 during CONV → no done_tick; display returns to the reset value "000" with digit3 blank; ready=1 on the next edge.

Source files
------------

// File: rtl/sign_mag_pkg.sv
// Shared types and constants for the sign-magnitude display path:
// converter FSM states, special segment codes, digit-to-segment lookup
// and the legal range of the input width N.
package sign_mag_pkg;

    // Legal input width range; N-1 magnitude bits must fit three BCD digits
    localparam int unsigned N_MIN = 2;
    localparam int unsigned N_MAX = 10;

    // Active-low segment patterns, bit7 = dp, bits6:0 = g..a
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } conv_state_e;

    // Decimal digit to active-low segment code; dp always off
    function automatic logic [7:0] seg_of_digit(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sm_bcd_conv.sv
// Sequential sign-magnitude to BCD converter. Captures sign and magnitude
// on an accepted start, runs N-1 shift-add-3 iterations, then pulses
// done_tick for one cycle while bcd/sign hold the final result.
// N must lie in sign_mag_pkg::N_MIN..N_MAX.
module sm_bcd_conv
    import sign_mag_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] sm_in,
    output logic         ready,
    output logic         done_tick,
    output logic [11:0]  bcd,
    output logic         sign
);

    localparam int unsigned MAG_W = N - 1;
    localparam int unsigned CNT_W = 4;

    conv_state_e      state_q, state_d;
    logic [MAG_W-1:0] mag_q, mag_d;
    logic [11:0]      bcd_q, bcd_d, bcd_adj;
    logic             sign_q, sign_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Add-3 correction of every BCD digit >= 5 ahead of the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        bcd_d     = bcd_q;
        sign_d    = sign_q;
        cnt_d     = cnt_q;
        ready     = 1'b0;
        done_tick = 1'b0;
        case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) begin
                    mag_d   = sm_in[N-2:0];
                    // Negative zero is shown without a minus sign
                    sign_d  = sm_in[N-1] & (|sm_in[N-2:0]);
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(MAG_W);
                    state_d = StConv;
                end
            end
            StConv: begin
                bcd_d = {bcd_adj[10:0], mag_q[MAG_W-1]};
                mag_d = mag_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_tick = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            mag_q   <= '0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bcd  = bcd_q;
    assign sign = sign_q;

endmodule

// File: rtl/sign_mag_disp.sv
// Four-digit multiplexed common-anode display of a sign-magnitude value.
// Digit3 shows the sign, digits 2..0 the decimal magnitude. A free-running
// refresh counter scans the digits; its top two bits pick the digit.
// Optional build macro SIGN_MAG_DISP_LZ_BLANK_EN blanks leading zeros of
// the hundreds and tens digits.
module sign_mag_disp
    import sign_mag_pkg::*;
#(
    parameter int unsigned N            = 8,
    parameter int unsigned REFRESH_BITS = 18
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] sm_in,
    output logic         ready,
    output logic         done_tick,
    output logic [3:0]   an,
    output logic [7:0]   sseg
);

    logic [11:0]             conv_bcd;
    logic                    conv_sign;
    logic [REFRESH_BITS-1:0] refresh_q;
    logic [11:0]             disp_bcd_q;
    logic                    disp_sign_q;
    logic [1:0]              sel;
    logic [7:0]              seg_hund, seg_tens, seg_ones;

    sm_bcd_conv #(
        .N (N)
    ) u_conv (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .sm_in     (sm_in),
        .ready     (ready),
        .done_tick (done_tick),
        .bcd       (conv_bcd),
        .sign      (conv_sign)
    );

    // Refresh counter and display registers; display updates only on done_tick
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            refresh_q   <= '0;
            disp_bcd_q  <= '0;
            disp_sign_q <= 1'b0;
        end else begin
            refresh_q <= refresh_q + REFRESH_BITS'(1);
            if (done_tick) begin
                disp_bcd_q  <= conv_bcd;
                disp_sign_q <= conv_sign;
            end
        end
    end

    assign sel = refresh_q[REFRESH_BITS-1 -: 2];

    // Segment codes of the magnitude digits, with optional leading-zero blanking
    always_comb begin
        seg_ones = seg_of_digit(disp_bcd_q[3:0]);
        seg_tens = seg_of_digit(disp_bcd_q[7:4]);
        seg_hund = seg_of_digit(disp_bcd_q[11:8]);
`ifdef SIGN_MAG_DISP_LZ_BLANK_EN
        if (disp_bcd_q[11:8] == 4'd0) begin
            seg_hund = SEG_BLANK;
            if (disp_bcd_q[7:4] == 4'd0) begin
                seg_tens = SEG_BLANK;
            end
        end
`endif
    end

    // Scan mux: enable one anode and route its segment code
    always_comb begin
        an      = 4'b1111;
        an[sel] = 1'b0;
        case (sel)
            2'd0:    sseg = seg_ones;
            2'd1:    sseg = seg_tens;
            2'd2:    sseg = seg_hund;
            default: sseg = disp_sign_q ? SEG_MINUS : SEG_BLANK;
        endcase
    end

endmodule

// File: tb/tb_sign_mag_disp.sv
// Self-checking bench for sign_mag_disp with N=8, REFRESH_BITS=4.
// Table vectors, random values against a decimal reference model, and
// hand sequences for ignored start and reset during conversion.
module tb_sign_mag_disp;

    localparam int unsigned N  = 8;
    localparam int unsigned RB = 4;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [N-1:0] sm_in;
    logic         ready;
    logic         done_tick;
    logic [3:0]   an;
    logic [7:0]   sseg;

    int tests = 0;
    int fails = 0;

    logic [7:0]    seg_tab [10];
    logic [RB-1:0] ref_cnt;

    typedef struct {
        logic [7:0] sm;
        logic [7:0] d3;
        logic [7:0] d2;
        logic [7:0] d1;
        logic [7:0] d0;
    } vec_t;

    vec_t vecs [6];

    sign_mag_disp #(
        .N            (N),
        .REFRESH_BITS (RB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .sm_in     (sm_in),
        .ready     (ready),
        .done_tick (done_tick),
        .an        (an),
        .sseg      (sseg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected refresh count: cleared by reset, otherwise +1 per edge
    always @(posedge clk) begin
        if (!reset_n) ref_cnt <= '0;
        else          ref_cnt <= ref_cnt + 4'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference: digit segment codes straight from the value
    task automatic model(input logic [7:0] v, output logic [7:0] d3, output logic [7:0] d2,
                         output logic [7:0] d1, output logic [7:0] d0);
        int mag;
        int h;
        int t;
        int o;
        mag = int'(v[6:0]);
        h   = mag / 100;
        t   = (mag / 10) % 10;
        o   = mag % 10;
        d3  = (v[7] && mag != 0) ? 8'hBF : 8'hFF;
        d2  = seg_tab[h];
        d1  = seg_tab[t];
        d0  = seg_tab[o];
`ifdef SIGN_MAG_DISP_LZ_BLANK_EN
        if (h == 0) d2 = 8'hFF;
        if (h == 0 && t == 0) d1 = 8'hFF;
`endif
    endtask

    // Watch the scan for a number of cycles against the expected digits
    task automatic check_scan(input string name, input logic [7:0] d3, input logic [7:0] d2,
                              input logic [7:0] d1, input logic [7:0] d0, input int cycles);
        logic [1:0] sel;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            sel         = ref_cnt[RB-1 -: 2];
            exp_an      = 4'b1111;
            exp_an[sel] = 1'b0;
            case (sel)
                2'd0:    exp_seg = d0;
                2'd1:    exp_seg = d1;
                2'd2:    exp_seg = d2;
                default: exp_seg = d3;
            endcase
            chk({name, " an"}, 32'(an), 32'(exp_an));
            chk({name, " sseg"}, 32'(sseg), 32'(exp_seg));
        end
    endtask

    // Launch one conversion; optionally pulse a second start during CONV
    task automatic do_conv(input string name, input logic [7:0] v, input int glitch_at);
        int lat;
        int ndone;
        lat   = 0;
        ndone = 0;
        @(negedge clk);
        chk({name, " ready idle"}, 32'(ready), 32'd1);
        start = 1'b1;
        sm_in = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        sm_in = 8'($urandom);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == glitch_at + 1) start = 1'b0;
            if (i == glitch_at) begin
                start = 1'b1;
                sm_in = 8'h01;
            end
            if (done_tick) begin
                ndone++;
                if (lat == 0) lat = i;
            end
            if (i == 1 || i == int'(N)) chk({name, " ready busy"}, 32'(ready), 32'd0);
        end
        chk({name, " latency"}, 32'(lat), 32'(N));
        chk({name, " done count"}, 32'(ndone), 32'd1);
        chk({name, " ready after"}, 32'(ready), 32'd1);
    endtask

    initial begin
        logic [7:0] d3, d2, d1, d0;
        logic [7:0] v;
        int nd;

        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
`ifdef SIGN_MAG_DISP_LZ_BLANK_EN
        vecs[0] = '{8'h85, 8'hBF, 8'hFF, 8'hFF, 8'h92};
        vecs[3] = '{8'h80, 8'hFF, 8'hFF, 8'hFF, 8'hC0};
        vecs[4] = '{8'h0A, 8'hFF, 8'hFF, 8'hF9, 8'hC0};
`else
        vecs[0] = '{8'h85, 8'hBF, 8'hC0, 8'hC0, 8'h92};
        vecs[3] = '{8'h80, 8'hFF, 8'hC0, 8'hC0, 8'hC0};
        vecs[4] = '{8'h0A, 8'hFF, 8'hC0, 8'hF9, 8'hC0};
`endif
        vecs[1] = '{8'h7F, 8'hFF, 8'hF9, 8'hA4, 8'hF8};
        vecs[2] = '{8'hFF, 8'hBF, 8'hF9, 8'hA4, 8'hF8};
        vecs[5] = '{8'hE4, 8'hBF, 8'hF9, 8'hC0, 8'hC0};

        reset_n = 1'b0;
        start   = 1'b0;
        sm_in   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset done", 32'(done_tick), 32'd0);
        chk("reset an", 32'(an), 32'h0000000E);
        chk("reset sseg", 32'(sseg), 32'h000000C0);
        reset_n = 1'b1;
        model(8'h00, d3, d2, d1, d0);
        check_scan("reset scan", d3, d2, d1, d0, 20);

        for (int k = 0; k < 6; k++) begin
            do_conv($sformatf("vec%0d", k), vecs[k].sm, 0);
            check_scan($sformatf("vec%0d scan", k), vecs[k].d3, vecs[k].d2, vecs[k].d1,
                       vecs[k].d0, 16);
        end

        // Second start three cycles into CONV must be ignored
        do_conv("ignored start", 8'h85, 3);
        sm_in = 8'h00;
        check_scan("ignored start scan", vecs[0].d3, vecs[0].d2, vecs[0].d1, vecs[0].d0, 16);

        for (int k = 0; k < 20; k++) begin
            v = 8'($urandom_range(0, 255));
            model(v, d3, d2, d1, d0);
            do_conv($sformatf("rand%0d %0h", k, v), v, 0);
            check_scan($sformatf("rand%0d %0h scan", k, v), d3, d2, d1, d0, 16);
        end

        // Reset during CONV: no done_tick, display back to reset value
        do_conv("pre-abort", 8'hFF, 0);
        @(negedge clk);
        start = 1'b1;
        sm_in = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        nd = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) chk("abort ready", 32'(ready), 32'd1);
            if (done_tick) nd++;
        end
        chk("abort done count", 32'(nd), 32'd0);
        model(8'h00, d3, d2, d1, d0);
        check_scan("abort scan", d3, d2, d1, d0, 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
